led_pattern_ctrl: RTL and testbench
===================================

// Module: led_pattern_ctrl
// PURPOSE
//  Sequencer for the board's 5 user LEDs, driven by the 5 user buttons.
//  - Synchronises and debounces each raw button, then turns presses into 1-cycle pulses.
//  - Drives the LEDs in one of four modes: direct mirror, blink, chase or bounce.
//  - Sits in the sys_clk domain, between the board pads and the LED pins,
//    replacing the direct button-to-LED wiring.
// PARAMETERS
//  NUM_BTN       5           number of buttons; also the number of LEDs
//  DEBOUNCE_CYC  1_562_500   cycles a new level must persist to be accepted (10 ms @156.25 MHz)
//  STEP_CYC      15_625_000  cycles per pattern step (100 ms @156.25 MHz)
// PORTS
//  sys_clk    in   1        system clock, single clock domain
//  sys_rst_n  in   1        asynchronous, active-low reset
//  btn_i      in   NUM_BTN  raw, asynchronous button levels (1 = pressed)
//  led_o      out  NUM_BTN  LED drive (1 = on), registered
//  mode_o     out  2        current mode, registered (0 DIRECT, 1 BLINK, 2 CHASE, 3 BOUNCE)
//  paused_o   out  1        1 = pattern stepping frozen, registered
// BEHAVIOUR
//  Reset (asynchronous assert, synchronous release):
//   - led_o=0, mode_o=DIRECT, paused_o=0.
//   - Debounced levels=0, synchronisers=0, all counters=0, bounce direction=up.
//  Input conditioning, per button:
//   - 2-FF synchroniser.
//   - Debounced level changes only after the synced sample has differed from it for
//     DEBOUNCE_CYC consecutive cycles; any agreeing sample clears the counter.
//   - press[i] = 1-cycle pulse on the 0->1 edge of the debounced level.
//   - Latency, btn_i edge -> debounced edge: 2 + DEBOUNCE_CYC cycles; led_o (DIRECT) follows +1 cycle.
//  Step tick:
//   - Prescaler counts 0..STEP_CYC-1; tick = 1-cycle pulse at terminal count, then wraps to 0.
//   - Held while paused; cleared on a mode change or restart.
//  Controls:
//   - press[0]: mode advances DIRECT->BLINK->CHASE->BOUNCE->DIRECT.
//     The next cycle loads the new mode's entry pattern and clears paused.
//   - press[1]: toggles paused; ignored in DIRECT.
//   - press[2]: restarts the current pattern (entry value, prescaler=0, paused=0); ignored in DIRECT.
//   - Simultaneous presses: press[0] wins over press[2], and press[2] wins over press[1].
//     The losing presses are dropped, not queued.
//  Modes (led_o update is registered; a tick changes led_o on the following cycle):
//   - DIRECT: led_o = debounced levels. All buttons, including btn0, mirror while cycling modes.
//   - BLINK: entry 00000; every tick, led_o = ~led_o.
//   - CHASE: entry 00001; every tick, rotate left; bit NUM_BTN-1 wraps to bit 0.
//   - BOUNCE: entry 00001, direction up; every tick, shift one place in the current direction.
//     On reaching bit NUM_BTN-1 the direction flips to down; on reaching bit 0 it flips to up.
//     Ends are visited once per sweep: 00001,00010,...,10000,01000,...,00001.
//  Reset asserted mid-pattern: immediate return to reset values; the pattern is not resumed.
//  Counter widths are $clog2(param); no counter may overflow for any parameter >= 2.
// STRUCTURE
//  - Package led_pkg:
//    - typedef enum logic [1:0] led_mode_e {DIRECT, BLINK, CHASE, BOUNCE}
//    - NUM_BTN default
//    - entry-pattern constants
//  - Sub-module btn_debounce: synchroniser, debounce counter and press pulse, one button.
//    Instantiated NUM_BTN times in a generate loop.
//  - Top holds the prescaler, mode/pause registers and pattern registers.
// TESTING (bench parameters DEBOUNCE_CYC=4, STEP_CYC=8)
//  1. Reset, then btn3=1 held -> led_o=01000 exactly 7 cycles later.
//     btn3=0 -> led_o=00000 7 cycles later; mode_o stays 0.
//  2. btn0 high for 3 cycles, then low -> no press; mode_o=0.
//     btn0 high for 4 cycles -> mode_o=1, led_o=00000; led_o=11111 after 8 more cycles.
//  3. Two more btn0 presses -> mode_o=3, led_o=00001; ticks every 8 cycles give
//     00010,00100,01000,10000,01000,00100,00010,00001.
//  4. In CHASE: btn1 press -> paused_o=1, led_o frozen for 100 cycles.
//     btn1 again -> resumes from the frozen value. btn2 -> led_o=00001, paused_o=0.
//  5. btn0, btn1 and btn2 debounced on the same cycle in CHASE -> mode_o=3, paused_o=0, led_o=00001.
//  6. sys_rst_n pulsed low mid-BOUNCE -> led_o=0, mode_o=0, paused_o=0 the same cycle.
//     After release, buttons low -> led_o stays 00000.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Brief    : Shared mode encoding and entry patterns for the LED sequencer.
// Revision : 1.0
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        DIRECT = 2'd0,
        BLINK  = 2'd1,
        CHASE  = 2'd2,
        BOUNCE = 2'd3
    } led_mode_e;

    localparam int unsigned c_num_btn     = 5;
    localparam int unsigned c_entry_blink = 0;
    localparam int unsigned c_entry_walk  = 1;

    function automatic led_mode_e next_mode(input led_mode_e mode);
        case (mode)
            DIRECT:  return BLINK;
            BLINK:   return CHASE;
            CHASE:   return BOUNCE;
            default: return DIRECT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : One button: 2-FF synchroniser, persistence debounce, press pulse.
// Revision : 1.0
// ============================================================================
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1_562_500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned       c_cnt_w    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYC - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Any sample agreeing with the accepted level restarts the persistence window.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_ctrl
// Brief    : Button-driven LED sequencer: direct, blink, chase and bounce modes.
// Revision : 1.0
// ============================================================================
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned NUM_BTN      = c_num_btn,
    parameter int unsigned DEBOUNCE_CYC = 1_562_500,
    parameter int unsigned STEP_CYC     = 15_625_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] led_o,
    output logic [1:0]         mode_o,
    output logic               paused_o
);

    localparam int unsigned         c_presc_w     = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last  = c_presc_w'(STEP_CYC - 1);
    localparam logic [NUM_BTN-1:0]   c_blink_entry = NUM_BTN'(c_entry_blink);
    localparam logic [NUM_BTN-1:0]   c_walk_entry  = NUM_BTN'(c_entry_walk);

    logic [NUM_BTN-1:0]   w_level;
    logic [NUM_BTN-1:0]   w_press;

    led_mode_e            r_mode;
    logic                 r_paused;
    logic [NUM_BTN-1:0]   r_led;
    logic [c_presc_w-1:0] r_presc;
    logic                 r_dir_up;

    led_mode_e            w_mode_nxt;
    logic                 w_paused_nxt;
    logic [NUM_BTN-1:0]   w_led_nxt;
    logic [c_presc_w-1:0] w_presc_nxt;
    logic                 w_dir_nxt;
    logic                 w_run;
    logic                 w_tick;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_btn_debounce (
                .clk     (sys_clk),
                .rst_n   (sys_rst_n),
                .i_btn   (btn_i[gi]),
                .o_level (w_level[gi]),
                .o_press (w_press[gi])
            );
        end
        // Only buttons 0..2 act as controls; the rest just mirror in DIRECT.
        if (NUM_BTN > 3) begin : g_spare_press
            logic w_unused_press;
            assign w_unused_press = ^w_press[NUM_BTN-1:3];
        end
    endgenerate

    function automatic logic [NUM_BTN-1:0] f_entry(input led_mode_e mode,
                                                   input logic [NUM_BTN-1:0] level);
        case (mode)
            DIRECT:  return level;
            BLINK:   return c_blink_entry;
            default: return c_walk_entry;
        endcase
    endfunction

    assign w_run  = (r_mode != DIRECT) && !r_paused;
    assign w_tick = w_run && (r_presc == c_presc_last);

    always_comb begin
        w_mode_nxt   = r_mode;
        w_paused_nxt = r_paused;
        w_led_nxt    = r_led;
        w_presc_nxt  = r_presc;
        w_dir_nxt    = r_dir_up;

        if (w_run) begin
            w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        end

        if (w_tick) begin
            case (r_mode)
                BLINK: w_led_nxt = ~r_led;
                CHASE: w_led_nxt = {r_led[NUM_BTN-2:0], r_led[NUM_BTN-1]};
                BOUNCE: begin
                    // Direction flips as the lit bit arrives at an end, so each end is shown once.
                    if (r_dir_up) begin
                        w_led_nxt = r_led << 1;
                        if (r_led[NUM_BTN-2]) w_dir_nxt = 1'b0;
                    end else begin
                        w_led_nxt = r_led >> 1;
                        if (r_led[1]) w_dir_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (r_mode == DIRECT) begin
            w_led_nxt = w_level;
        end

        // Later assignments override earlier ones: press[0] > press[2] > press[1].
        if (w_press[1] && (r_mode != DIRECT)) begin
            w_paused_nxt = ~r_paused;
        end

        if (w_press[2] && (r_mode != DIRECT)) begin
            w_led_nxt    = f_entry(r_mode, w_level);
            w_presc_nxt  = '0;
            w_paused_nxt = 1'b0;
            w_dir_nxt    = 1'b1;
        end

        if (w_press[0]) begin
            w_mode_nxt   = next_mode(r_mode);
            w_led_nxt    = f_entry(next_mode(r_mode), w_level);
            w_presc_nxt  = '0;
            w_paused_nxt = 1'b0;
            w_dir_nxt    = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode   <= DIRECT;
            r_paused <= 1'b0;
            r_led    <= '0;
            r_presc  <= '0;
            r_dir_up <= 1'b1;
        end else begin
            r_mode   <= w_mode_nxt;
            r_paused <= w_paused_nxt;
            r_led    <= w_led_nxt;
            r_presc  <= w_presc_nxt;
            r_dir_up <= w_dir_nxt;
        end
    end

    assign led_o    = r_led;
    assign mode_o   = r_mode;
    assign paused_o = r_paused;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_ctrl
// Brief    : Scoreboard bench for led_pattern_ctrl against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_led_pattern_ctrl;

    localparam int N    = 5;
    localparam int DEB  = 4;
    localparam int STEP = 8;

    logic         sys_clk   = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic [N-1:0] btn_i     = '0;
    logic [N-1:0] led_o;
    logic [1:0]   mode_o;
    logic         paused_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [N-1:0] led;
        logic [1:0]   mode;
        logic         paused;
    } exp_t;

    exp_t exp_q[$];

    always #5 sys_clk = ~sys_clk;

    led_pattern_ctrl #(
        .NUM_BTN      (N),
        .DEBOUNCE_CYC (DEB),
        .STEP_CYC     (STEP)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .btn_i     (btn_i),
        .led_o     (led_o),
        .mode_o    (mode_o),
        .paused_o  (paused_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [N-1:0] m_hist[$];   // raw button values at the last two edges
    logic [N-1:0] m_seen[$];   // last DEB samples after the synchroniser delay
    logic [N-1:0] m_lvl;
    logic [N-1:0] m_lvl_old;
    logic [N-1:0] m_led;
    int           m_mode;
    int           m_steps;     // pattern steps taken since entry/restart
    int           m_elapsed;   // unpaused cycles since entry/restart
    bit           m_paused;

    function automatic logic [N-1:0] pattern_of(input int mode, input int steps,
                                                input logic [N-1:0] lvl);
        int p;
        case (mode)
            0: return lvl;
            1: return (steps % 2) ? {N{1'b1}} : {N{1'b0}};
            2: return N'(1) << (steps % N);
            default: begin
                p = steps % (2 * N - 2);
                return N'(1) << ((p < N) ? p : (2 * N - 2 - p));
            end
        endcase
    endfunction

    task automatic model_reset();
        m_hist = {};
        m_seen = {};
        repeat (2) m_hist.push_back('0);
        repeat (DEB) m_seen.push_back('0);
        m_lvl     = '0;
        m_lvl_old = '0;
        m_led     = '0;
        m_mode    = 0;
        m_steps   = 0;
        m_elapsed = 0;
        m_paused  = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] btn);
        logic [N-1:0] press;
        logic [N-1:0] sample;
        logic [N-1:0] flip;
        bit           active;
        press  = m_lvl & ~m_lvl_old;
        active = (m_mode != 0) && !m_paused;
        if (press[0]) begin
            m_mode    = (m_mode + 1) % 4;
            m_paused  = 1'b0;
            m_elapsed = 0;
            m_steps   = 0;
        end else if (press[2] && m_mode != 0) begin
            m_paused  = 1'b0;
            m_elapsed = 0;
            m_steps   = 0;
        end else begin
            if (active) begin
                m_elapsed++;
                if (m_elapsed % STEP == 0) m_steps++;
            end
            if (press[1] && m_mode != 0) m_paused = !m_paused;
        end
        m_led = pattern_of(m_mode, m_steps, m_lvl);
        // Level flips only where the whole window of DEB samples disagrees with it.
        sample = m_hist.pop_front();
        m_hist.push_back(btn);
        void'(m_seen.pop_front());
        m_seen.push_back(sample);
        flip = '1;
        foreach (m_seen[j]) flip &= m_seen[j] ^ m_lvl;
        m_lvl_old = m_lvl;
        m_lvl     = m_lvl ^ flip;
    endtask

    initial model_reset();

    always @(posedge sys_clk) begin
        if (!sys_rst_n) model_reset();
        else            model_step(btn_i);
        exp_q.push_back({m_led, 2'(m_mode), m_paused});
    end

    // ---------------- monitor ----------------
    always @(negedge sys_clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got no expected entry, required one at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("led", 32'(led_o), 32'(e.led));
            check("mode", 32'(mode_o), 32'(e.mode));
            check("paused", 32'(paused_o), 32'(e.paused));
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [N-1:0] v, input int n);
        btn_i = v;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic press_btn(input int b);
        hold(N'(1) << b, DEB + 1);
        hold('0, DEB + 4);
    endtask

    task automatic pulse_reset();
        #2 sys_rst_n = 1'b0;
        #2;
        check("rst_async_led", 32'(led_o), 32'h0);
        check("rst_async_mode", 32'(mode_o), 32'h0);
        check("rst_async_paused", 32'(paused_o), 32'h0);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check("reset_led", 32'(led_o), 32'h0);
        check("reset_mode", 32'(mode_o), 32'h0);

        // Direct mirror latency
        btn_i = 5'b01000;
        repeat (6) @(negedge sys_clk);
        check("direct_on_6", 32'(led_o), 32'h0);
        @(negedge sys_clk);
        check("direct_on_7", 32'(led_o), 32'h08);
        btn_i = '0;
        repeat (7) @(negedge sys_clk);
        check("direct_off_7", 32'(led_o), 32'h0);
        check("direct_mode", 32'(mode_o), 32'h0);
        hold('0, 3);

        // Short glitch rejected, full-length press accepted
        hold(5'b00001, DEB - 1);
        hold('0, 10);
        check("glitch_mode", 32'(mode_o), 32'h0);
        hold(5'b00001, DEB);
        hold('0, 20);
        check("blink_mode", 32'(mode_o), 32'h1);

        // Bounce sweep
        press_btn(0);
        press_btn(0);
        check("bounce_mode", 32'(mode_o), 32'h3);
        hold('0, 9 * STEP);

        // Chase with pause, resume, restart
        press_btn(0);
        press_btn(0);
        press_btn(0);
        hold('0, 3 * STEP);
        press_btn(1);
        check("pause_set", 32'(paused_o), 32'h1);
        hold('0, 100);
        press_btn(1);
        hold('0, 3 * STEP + 3);
        press_btn(2);
        hold('0, 2 * STEP);

        // Simultaneous presses
        hold(5'b00111, DEB + 1);
        hold('0, DEB + 4);
        check("simul_mode", 32'(mode_o), 32'h3);
        check("simul_paused", 32'(paused_o), 32'h0);
        hold('0, 3 * STEP + 2);

        // Reset mid-pattern
        pulse_reset();
        hold('0, 30);
        check("post_reset_led", 32'(led_o), 32'h0);

        // Randomised buttons
        for (int k = 0; k < 300; k++) begin
            logic [N-1:0] v;
            v = N'($urandom);
            if ($urandom_range(0, 1) == 0) v = '0;
            hold(v, $urandom_range(1, 12));
            if ($urandom_range(0, 80) == 0) pulse_reset();
        end
        hold('0, 20);

        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
